// File: rtl/clock_input_conditioner.sv
// Front end of the real-time clock counter: seconds divider, switch synchronisers, button debouncers.
// Define FAST_SET_EN to add hold-to-repeat adjust strobes while in set mode.

module clock_input_conditioner #(
    parameter int CLK_HZ       = 50000000,
    parameter int TICK_HZ      = 1,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_CYC   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn_n,
    input  logic       stop_sw,
    input  logic       inc_sw,
    output logic       tick_en,
    output logic [5:0] adj,
    output logic       is_stop,
    output logic       is_inc
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

    logic [5:0]       btn_s1_q, btn_s1_d;
    logic [5:0]       btn_s2_q, btn_s2_d;
    logic [1:0]       sw_s1_q, sw_s1_d;
    logic [1:0]       sw_s2_q, sw_s2_d;
    logic [1:0]       settle_q, settle_d;
    logic [5:0]       state_q, state_d;
    logic [5:0]       armed_q, armed_d;
    logic [5:0]       press_q, press_d;
    logic [DB_W-1:0]  db_cnt_q [6];
    logic [DB_W-1:0]  db_cnt_d [6];
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [5:0]       adj_q, adj_d;
    logic [5:0]       flip_press;
    logic [5:0]       rpt_fire;
    logic             stop_s;

    assign stop_s = sw_s2_q[0];

    // Switch bit 0 is stop_sw, bit 1 is inc_sw.
    always_comb begin
        btn_s1_d = btn_n;
        btn_s2_d = btn_s1_q;
        sw_s1_d  = {inc_sw, stop_sw};
        sw_s2_d  = sw_s1_q;
        settle_d = {settle_q[0], 1'b1};
    end

    // state_q bit = 1 means debounced pressed. A button only strobes once it has been
    // seen released after reset, so a button held through reset stays silent until re-pressed.
    // settle_q[1] masks the reset values still sitting in the synchroniser.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        flip_press = '0;
        for (int i = 0; i < 6; i++) begin
            db_cnt_d[i] = '0;
            armed_d[i]  = armed_q[i] | (settle_q[1] & btn_s2_q[i]);
            if ((~btn_s2_q[i]) != state_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    state_d[i]    = ~btn_s2_q[i];
                    flip_press[i] = ~btn_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
        press_d = armed_q & (flip_press | rpt_fire);
    end

`ifdef FAST_SET_EN
    localparam int REP_W = $clog2(2 * REPEAT_CYC);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(2 * REPEAT_CYC - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_CYC);

    logic [REP_W-1:0] rep_cnt_q [6];
    logic [REP_W-1:0] rep_cnt_d [6];

    // Counter starts at the initial press; reloading to REPEAT_CYC after each fire turns
    // the 2*REPEAT_CYC first gap into a REPEAT_CYC steady-state period.
    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < 6; i++) begin
            rep_cnt_d[i] = '0;
            if (state_q[i] && stop_s) begin
                if (rep_cnt_q[i] == REP_LAST) begin
                    rep_cnt_d[i] = REP_RELOAD;
                    rpt_fire[i]  = 1'b1;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                rep_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

    // Set mode: enable and strobes come from the same registered press vector so the
    // counter sees them in the same cycle. Run mode: presses are dropped, divider ticks.
    always_comb begin
        div_d  = '0;
        tick_d = 1'b0;
        adj_d  = '0;
        if (stop_s) begin
            adj_d  = press_q;
            tick_d = |press_q;
        end else begin
            tick_d = (div_q == DIV_LAST);
            if (div_q != DIV_LAST) begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q <= '1;
            btn_s2_q <= '1;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            settle_q <= '0;
            state_q  <= '0;
            armed_q  <= '0;
            press_q  <= '0;
            div_q    <= '0;
            tick_q   <= 1'b0;
            adj_q    <= '0;
            for (int i = 0; i < 6; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            btn_s1_q <= btn_s1_d;
            btn_s2_q <= btn_s2_d;
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            settle_q <= settle_d;
            state_q  <= state_d;
            armed_q  <= armed_d;
            press_q  <= press_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            adj_q    <= adj_d;
            for (int i = 0; i < 6; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign tick_en = tick_q;
    assign adj     = adj_q;
    assign is_stop = sw_s2_q[0];
    assign is_inc  = sw_s2_q[1];

endmodule

// File: tb/tb_clock_input_conditioner.sv
// Self-checking bench for clock_input_conditioner (DIV=20, DEBOUNCE_CYC=4, REPEAT_CYC=8).
// Events are {cycle, tick_en, adj}; cycle = number of rising edges seen when sampled at the falling edge.

module tb_clock_input_conditioner;

    localparam int EW = 39;

    logic       clk;
    logic       rst;
    logic [5:0] btn_n;
    logic       stop_sw;
    logic       inc_sw;
    logic       tick_en;
    logic [5:0] adj;
    logic       is_stop;
    logic       is_inc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rel_cyc;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];

    clock_input_conditioner #(
        .CLK_HZ      (20),
        .TICK_HZ     (1),
        .DEBOUNCE_CYC(4),
        .REPEAT_CYC  (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_n  (btn_n),
        .stop_sw(stop_sw),
        .inc_sw (inc_sw),
        .tick_en(tick_en),
        .adj    (adj),
        .is_stop(is_stop),
        .is_inc (is_inc)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Driver: advance to falling edge number t, logging every non-idle output cycle.
    task automatic goto(input int t);
        while (cyc < t) begin
            @(negedge clk);
            if (tick_en || adj != 6'd0) obs_q.push_back({cyc, tick_en, adj});
        end
    endtask

    function automatic logic [EW-1:0] ev(input int c, input logic t, input logic [5:0] a);
        return {c, t, a};
    endfunction

    task automatic test_reset();
        rst = 1'b1; stop_sw = 1'b1; inc_sw = 1'b1; btn_n = 6'b010101;
        goto(cyc + 3);
        checks++; if (tick_en !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b, expected 0", tick_en); end
        checks++; if (adj !== 6'd0) begin errors++; $display("FAIL reset_adj: got %b, expected 000000", adj); end
        checks++; if (is_stop !== 1'b0) begin errors++; $display("FAIL reset_is_stop: got %b, expected 0", is_stop); end
        checks++; if (is_inc !== 1'b0) begin errors++; $display("FAIL reset_is_inc: got %b, expected 0", is_inc); end
        stop_sw = 1'b0; inc_sw = 1'b0; btn_n = '1;
        goto(cyc + 1);
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic test_run_ticks();
        logic [EW-1:0] e, o;
        int r = rel_cyc;
        for (int k = 1; k <= 5; k++) exp_q.push_back(ev(r + 20 * k, 1'b1, 6'd0));
        inc_sw = 1'b1;
        goto(r + 1);
        checks++; if (is_inc !== 1'b0) begin errors++; $display("FAIL inc_sync_stage1: got %b, expected 0", is_inc); end
        goto(r + 2);
        checks++; if (is_inc !== 1'b1) begin errors++; $display("FAIL inc_sync_stage2: got %b, expected 1", is_inc); end
        inc_sw = 1'b0;
        goto(r + 100);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); errors++;
                $display("FAIL run_ticks: got nothing, expected cyc=%0d tick=%0b adj=%b", e[38:7], e[6], e[5:0]);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); errors++;
                $display("FAIL run_ticks: got cyc=%0d tick=%0b adj=%b, expected nothing", o[38:7], o[6], o[5:0]);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL run_ticks: got cyc=%0d tick=%0b adj=%b, expected cyc=%0d tick=%0b adj=%b",
                             o[38:7], o[6], o[5:0], e[38:7], e[6], e[5:0]);
                end
            end
        end
    endtask

    task automatic test_single_press();
        logic [EW-1:0] e, o;
        int c = cyc;
        int d;
        stop_sw = 1'b1;
        goto(c + $urandom_range(3, 8));
        d = cyc;
        btn_n[1] = 1'b0;
        exp_q.push_back(ev(d + 7, 1'b1, 6'b000010));
        goto(d + 20);
        btn_n[1] = 1'b1;
        goto(d + 32);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); errors++;
                $display("FAIL single_press: got nothing, expected cyc=%0d tick=%0b adj=%b", e[38:7], e[6], e[5:0]);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); errors++;
                $display("FAIL single_press: got cyc=%0d tick=%0b adj=%b, expected nothing", o[38:7], o[6], o[5:0]);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL single_press: got cyc=%0d tick=%0b adj=%b, expected cyc=%0d tick=%0b adj=%b",
                             o[38:7], o[6], o[5:0], e[38:7], e[6], e[5:0]);
                end
            end
        end
    endtask

    task automatic test_glitch_and_multi();
        logic [EW-1:0] e, o;
        int c = cyc;
        int d;
        btn_n[0] = 1'b0; goto(c + 3);
        btn_n[0] = 1'b1; goto(c + 5);
        btn_n[0] = 1'b0; goto(c + 8);
        btn_n[0] = 1'b1;
        goto(c + 8 + $urandom_range(4, 8));
        d = cyc;
        btn_n[0] = 1'b0;
        btn_n[5] = 1'b0;
        exp_q.push_back(ev(d + 7, 1'b1, 6'b100001));
        goto(d + 18);
        btn_n = '1;
        goto(d + 30);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); errors++;
                $display("FAIL glitch_multi: got nothing, expected cyc=%0d tick=%0b adj=%b", e[38:7], e[6], e[5:0]);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); errors++;
                $display("FAIL glitch_multi: got cyc=%0d tick=%0b adj=%b, expected nothing", o[38:7], o[6], o[5:0]);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL glitch_multi: got cyc=%0d tick=%0b adj=%b, expected cyc=%0d tick=%0b adj=%b",
                             o[38:7], o[6], o[5:0], e[38:7], e[6], e[5:0]);
                end
            end
        end
    endtask

    task automatic test_mode_change();
        logic [EW-1:0] e, o;
        int c = cyc;
        stop_sw = 1'b0;
        exp_q.push_back(ev(c + 22, 1'b1, 6'd0));
        exp_q.push_back(ev(c + 42, 1'b1, 6'd0));
        goto(c + 24); btn_n[3] = 1'b0;
        goto(c + 34); btn_n[3] = 1'b1;
        goto(c + 50); stop_sw = 1'b1;
        goto(c + 51);
        checks++; if (is_stop !== 1'b0) begin errors++; $display("FAIL stop_sync_stage1: got %b, expected 0", is_stop); end
        goto(c + 52);
        checks++; if (is_stop !== 1'b1) begin errors++; $display("FAIL stop_sync_stage2: got %b, expected 1", is_stop); end
        goto(c + 57); stop_sw = 1'b0;
        exp_q.push_back(ev(c + 79, 1'b1, 6'd0));
        exp_q.push_back(ev(c + 99, 1'b1, 6'd0));
        goto(c + 105);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); errors++;
                $display("FAIL mode_change: got nothing, expected cyc=%0d tick=%0b adj=%b", e[38:7], e[6], e[5:0]);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); errors++;
                $display("FAIL mode_change: got cyc=%0d tick=%0b adj=%b, expected nothing", o[38:7], o[6], o[5:0]);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL mode_change: got cyc=%0d tick=%0b adj=%b, expected cyc=%0d tick=%0b adj=%b",
                             o[38:7], o[6], o[5:0], e[38:7], e[6], e[5:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_press();
        logic [EW-1:0] e, o;
        int c = cyc;
        stop_sw = 1'b1;
        goto(c + 6); btn_n[2] = 1'b0;
        goto(c + 8); rst = 1'b1;
        #1;
        checks++; if (is_stop !== 1'b0) begin errors++; $display("FAIL midrst_is_stop: got %b, expected 0", is_stop); end
        checks++; if (tick_en !== 1'b0) begin errors++; $display("FAIL midrst_tick: got %b, expected 0", tick_en); end
        checks++; if (adj !== 6'd0) begin errors++; $display("FAIL midrst_adj: got %b, expected 000000", adj); end
        goto(c + 10); rst = 1'b0;
        goto(c + 30); btn_n[2] = 1'b1;
        goto(c + 40); btn_n[2] = 1'b0;
        exp_q.push_back(ev(c + 47, 1'b1, 6'b000100));
        goto(c + 55); btn_n[2] = 1'b1;
        goto(c + 65);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); errors++;
                $display("FAIL reset_mid_press: got nothing, expected cyc=%0d tick=%0b adj=%b", e[38:7], e[6], e[5:0]);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); errors++;
                $display("FAIL reset_mid_press: got cyc=%0d tick=%0b adj=%b, expected nothing", o[38:7], o[6], o[5:0]);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL reset_mid_press: got cyc=%0d tick=%0b adj=%b, expected cyc=%0d tick=%0b adj=%b",
                             o[38:7], o[6], o[5:0], e[38:7], e[6], e[5:0]);
                end
            end
        end
    endtask

    task automatic test_hold_repeat();
        logic [EW-1:0] e, o;
        int c = cyc;
        int t0 = c + 7;
        btn_n[4] = 1'b0;
        exp_q.push_back(ev(t0, 1'b1, 6'b010000));
`ifdef FAST_SET_EN
        // Release is sampled at edge c+61, so the debounced state drops at edge c+66.
        for (int t = t0 + 16; t <= c + 66; t += 8) exp_q.push_back(ev(t, 1'b1, 6'b010000));
`endif
        goto(c + 60); btn_n[4] = 1'b1;
        goto(c + 80);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); errors++;
                $display("FAIL hold_repeat: got nothing, expected cyc=%0d tick=%0b adj=%b", e[38:7], e[6], e[5:0]);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); errors++;
                $display("FAIL hold_repeat: got cyc=%0d tick=%0b adj=%b, expected nothing", o[38:7], o[6], o[5:0]);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL hold_repeat: got cyc=%0d tick=%0b adj=%b, expected cyc=%0d tick=%0b adj=%b",
                             o[38:7], o[6], o[5:0], e[38:7], e[6], e[5:0]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; btn_n = '1; stop_sw = 1'b0; inc_sw = 1'b0;
        test_reset();
        test_run_ticks();
        test_single_press();
        test_glitch_and_multi();
        test_mode_change();
        test_reset_mid_press();
        test_hold_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
